// File: rtl/tick_gen_multi_if.sv
// Control/status bundle for the multi-channel tick generator.
// The master drives enables, modes, pulses and divisor writes; the slave returns ticks.
interface tick_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] oneshot;
    logic [NUM_CH-1:0] start;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;

    modport master (
        output en, oneshot, start, sync, cfg_we, cfg_ch, cfg_div,
        input  tick, active
    );

    modport slave (
        input  en, oneshot, start, sync, cfg_we, cfg_ch, cfg_div,
        output tick, active
    );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: periodic or one-shot ticks every DIV clocks,
// run-time divisor writes and a global sync that restarts all enabled channels.
module tick_gen_multi #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int DEFAULT_FREQ = 1,
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int CH_W         = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    tick_gen_multi_if.slave  bus
);
    localparam logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(CLK_FREQ / DEFAULT_FREQ);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] div_reg, div_next;
            logic             armed_reg, armed_next;
            logic             tick_reg, tick_next;
            logic             active_reg, active_next;
            logic [CNT_W-1:0] eff;
            logic             tc;
            logic             wr_hit;

            // A zero divisor behaves as one; >= keeps TC safe if cnt ever exceeds eff-1.
            assign eff    = (div_reg == '0) ? CNT_W'(1) : div_reg;
            assign tc     = (cnt_reg >= eff - CNT_W'(1));
            assign wr_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

            always_comb begin
                cnt_next    = cnt_reg;
                div_next    = div_reg;
                armed_next  = armed_reg;
                tick_next   = 1'b0;
                if (!bus.en[gi]) begin
                    cnt_next   = '0;
                    armed_next = 1'b0;
                end else if (wr_hit) begin
                    div_next = bus.cfg_div;
                    cnt_next = '0;
                end else if (bus.sync) begin
                    cnt_next = '0;
                end else if (bus.oneshot[gi] && bus.start[gi]) begin
                    armed_next = 1'b1;
                    cnt_next   = '0;
                end else if (!bus.oneshot[gi] || armed_reg) begin
                    if (tc) begin
                        cnt_next  = '0;
                        tick_next = 1'b1;
                        if (bus.oneshot[gi]) begin
                            armed_next = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                active_next = bus.en[gi] && (!bus.oneshot[gi] || armed_next);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    div_reg    <= DEFAULT_DIV;
                    armed_reg  <= 1'b0;
                    tick_reg   <= 1'b0;
                    active_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    div_reg    <= div_next;
                    armed_reg  <= armed_next;
                    tick_reg   <= tick_next;
                    active_reg <= active_next;
                end
            end

            assign bus.tick[gi]   = tick_reg;
            assign bus.active[gi] = active_reg;
        end
    endgenerate
endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: countdown reference model checked every cycle, directed
// scenarios pinned with literal tick/active patterns, then randomized traffic.
module tb_tick_gen_multi;
    localparam int NCH   = 4;
    localparam int CW    = 32;
    localparam int CHW   = 3;
    localparam int DEFD  = 10;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    tick_gen_multi_if #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) bus ();

    tick_gen_multi #(
        .CLK_FREQ(100), .DEFAULT_FREQ(10), .NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each channel counts down the cycles remaining until its next tick.
    int           div_m  [NCH];
    int           rem_m  [NCH];
    bit           armed_m[NCH];
    logic [NCH-1:0] tick_m, act_m;

    function automatic int eff_of(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                div_m[c] = DEFD; rem_m[c] = DEFD; armed_m[c] = 0;
            end
            tick_m = '0; act_m = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                tick_m[c] = 1'b0;
                if (!bus.en[c]) begin
                    rem_m[c] = eff_of(div_m[c]); armed_m[c] = 0;
                end else if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
                    div_m[c] = int'(bus.cfg_div); rem_m[c] = eff_of(div_m[c]);
                end else if (bus.sync) begin
                    rem_m[c] = eff_of(div_m[c]);
                end else if (bus.oneshot[c] && bus.start[c]) begin
                    armed_m[c] = 1; rem_m[c] = eff_of(div_m[c]);
                end else if (!bus.oneshot[c] || armed_m[c]) begin
                    rem_m[c] = rem_m[c] - 1;
                    if (rem_m[c] == 0) begin
                        tick_m[c] = 1'b1;
                        rem_m[c]  = eff_of(div_m[c]);
                        if (bus.oneshot[c]) armed_m[c] = 0;
                    end
                end
                act_m[c] = bus.en[c] && (!bus.oneshot[c] || armed_m[c]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            total++;
            if (bus.tick !== tick_m) begin
                bad++;
                $display("FAIL cyc_tick t=%0t actual=%b required=%b", $time, bus.tick, tick_m);
            end
            total++;
            if (bus.active !== act_m) begin
                bad++;
                $display("FAIL cyc_active t=%0t actual=%b required=%b", $time, bus.active, act_m);
            end
        end
    end

    logic [NCH-1:0] tlog[64];
    logic [NCH-1:0] alog[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs n edges (edge 0 is the first edge after call); pulses are dropped after edge 0.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tlog[i] = bus.tick;
            alog[i] = bus.active;
            if (i == 0) begin
                bus.start = '0; bus.sync = 1'b0; bus.cfg_we = 1'b0;
            end
        end
    endtask

    function automatic logic [63:0] tmask(input int ch, input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n; i++) m[i] = tlog[i][ch];
        return m;
    endfunction

    function automatic logic [63:0] amask(input int ch, input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n; i++) m[i] = alog[i][ch];
        return m;
    endfunction

    task automatic wr(input int ch, input int d);
        bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(ch); bus.cfg_div = CW'(d);
    endtask

    initial begin
        logic [NCH-1:0] en_n;
        int c;
        rst_n = 1'b0;
        bus.en = '0; bus.oneshot = '0; bus.start = '0; bus.sync = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
        repeat (3) @(negedge clk);
        chk("rst_tick", 64'(bus.tick), 64'h0);
        chk("rst_active", 64'(bus.active), 64'h0);
        bus.en[0] = 1'b1;
        @(negedge clk);
        chk("rst_hold_active", 64'(bus.active), 64'h0);
        rst_n = 1'b1;

        // Default divisor 10: ticks after edges 9, 19, 29.
        collect(30);
        chk("per_def_tick", tmask(0, 30), 64'h2008_0200);
        chk("per_def_active", amask(0, 30), 64'h3FFF_FFFF);

        // Async reset mid-count (cnt=5).
        collect(5);
        #3 rst_n = 1'b0;
        #1;
        chk("async_tick", 64'(bus.tick), 64'h0);
        chk("async_active", 64'(bus.active), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ch1 div 3, then div 0, then a write to a nonexistent channel.
        bus.en[1] = 1'b1; wr(1, 3);
        collect(10);
        chk("div3_tick", tmask(1, 10), 64'h248);
        wr(1, 0);
        collect(5);
        chk("div0_tick", tmask(1, 5), 64'h1E);
        wr(5, 2);
        collect(4);
        chk("badch_tick", tmask(1, 4), 64'hF);

        // ch2 one-shot div 4.
        bus.en[2] = 1'b1; bus.oneshot[2] = 1'b1; wr(2, 4);
        collect(1);
        bus.start[2] = 1'b1;
        collect(8);
        chk("os_tick", tmask(2, 8), 64'h10);
        chk("os_active", amask(2, 8), 64'hF);
        bus.start[2] = 1'b1;
        collect(2);
        chk("os_retrig_early", tmask(2, 2), 64'h0);
        bus.start[2] = 1'b1;
        collect(8);
        chk("os_retrig_tick", tmask(2, 8), 64'h10);
        bus.start[0] = 1'b1;
        collect(2);

        // Sync aligns ch0 (div 4) and ch1 (div 6).
        wr(0, 4); collect(1);
        wr(1, 6); collect(1);
        bus.sync = 1'b1;
        collect(13);
        chk("sync_ch0", tmask(0, 13), 64'h1110);
        chk("sync_ch1", tmask(1, 13), 64'h1040);

        // Write coincident with TC on ch3, then sync coincident with TC.
        bus.en[3] = 1'b1; wr(3, 5);
        collect(5);
        chk("tcw_pre", tmask(3, 5), 64'h0);
        wr(3, 2);
        collect(5);
        chk("tcw_tick", tmask(3, 5), 64'h14);
        collect(1);
        bus.sync = 1'b1;
        collect(3);
        chk("tcsync_tick", tmask(3, 3), 64'h4);

        // Drop enable mid-count (cnt=7 of 10), re-enable.
        wr(3, 10);
        collect(8);
        bus.en[3] = 1'b0;
        collect(2);
        chk("endrop_active", amask(3, 2), 64'h0);
        bus.en[3] = 1'b1;
        collect(11);
        chk("reen_tick", tmask(3, 11), 64'h200);

        // One-shot armed then disabled: no tick.
        bus.start[2] = 1'b1;
        collect(2);
        bus.en[2] = 1'b0;
        collect(1);
        bus.en[2] = 1'b1;
        collect(6);
        chk("os_endrop_tick", tmask(2, 6), 64'h0);
        chk("os_endrop_active", amask(2, 6), 64'h0);

        // Randomized traffic checked by the model.
        repeat (3000) begin
            @(negedge clk);
            en_n = bus.en;
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 49) == 0) en_n[k] = ~en_n[k];
                if (!en_n[k] && $urandom_range(0, 1) == 1) bus.oneshot[k] = ~bus.oneshot[k];
            end
            bus.en    = en_n;
            bus.start = NCH'($urandom_range(0, 15)) & NCH'($urandom_range(0, 15))
                        & NCH'($urandom_range(0, 15));
            bus.sync  = ($urandom_range(0, 31) == 0);
            c = $urandom_range(0, 7);
            bus.cfg_ch  = CHW'(c);
            bus.cfg_div = CW'($urandom_range(0, 9));
            bus.cfg_we  = ($urandom_range(0, 7) == 0);
            if (c < NCH && !en_n[c]) bus.cfg_we = 1'b0;
        end
        @(negedge clk);
        bus.start = '0; bus.sync = 1'b0; bus.cfg_we = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Multi-channel programmable tick generator.
- Each channel emits a one-cycle tick pulse every DIV clocks (periodic mode), or once DIV clocks after a start pulse (one-shot mode).
- Divisors are writable at run time through a simple config port, and a global sync input phase-aligns all channels.
- Sits in the clock/reset subsystem and feeds the timebase to UART baud, debounce, display-scan and 1 Hz timer logic.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz; used only to compute DEFAULT_DIV.
- DEFAULT_FREQ, 1: reset tick frequency in Hz. DEFAULT_DIV = CLK_FREQ / DEFAULT_FREQ.
- NUM_CH, 4: number of independent channels, from 1 to 16.
- CNT_W, 32: counter and divisor width.
- CH_W, 2: width of cfg_ch. Must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  NUM_CH  per-channel level enable.
- oneshot  in  NUM_CH  per-channel mode: 0 = periodic, 1 = one-shot.
- start  in  NUM_CH  per-channel one-cycle arm/retrigger pulse; used in one-shot mode only.
- sync  in  1  one-cycle pulse that restarts the counters of all enabled channels.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_div  in  CNT_W  new divisor value.
- tick  out  NUM_CH  registered one-cycle tick per channel.
- active  out  NUM_CH  high while a channel is counting toward a tick.

Behaviour:
- Reset is asynchronous, active-low, and applies to every channel:
  - div_reg = DEFAULT_DIV, cnt = 0, armed = 0.
  - tick = 0, active = 0.
- Effective divisor: eff = (div_reg == 0) ? 1 : div_reg. A divisor of 0 behaves exactly like 1.
- Terminal count (TC) is cnt >= eff - 1. The >= keeps this safe when a smaller divisor is written while cnt is high.
- Per-channel priority on each rising edge, highest first:
  1. en == 0: cnt <= 0, armed <= 0, tick <= 0.
  2. cfg_we && cfg_ch == this channel: div_reg <= cfg_div, cnt <= 0, tick <= 0. Armed state is unchanged.
  3. sync: cnt <= 0, tick <= 0.
  4. oneshot && start: armed <= 1, cnt <= 0, tick <= 0. A start while already armed retriggers from zero.
  5. Counting, performed when periodic or when armed:
     - TC reached: cnt <= 0 and tick <= 1. In one-shot mode, armed <= 0 as well.
     - Otherwise: cnt <= cnt + 1, tick <= 0.
  6. Idle (one-shot and not armed): cnt holds 0, tick <= 0.
- Periodic timing:
  - en rises before edge 0; with eff = N, tick is high after edge N-1, then after every further N edges.
  - Period is exactly N cycles, with exactly one high cycle per period.
  - N = 1 gives tick constantly high.
- One-shot timing: start is sampled at edge 0, and tick is high for exactly one cycle after edge N, then the channel is idle.
- active is registered combinationally from next state:
  - en && (!oneshot || armed_next).
  - In periodic mode, active = en.
- Write addressing:
  - cfg_ch >= NUM_CH: the write is ignored with no side effects.
  - Only the addressed channel is affected; other channels keep their phase.
- Mode change mid-count:
  - Periodic to one-shot: stops counting unless armed. armed is 0 unless a start arrives.
  - One-shot to periodic: resumes counting from the current cnt.
- start is ignored in periodic mode.
- Channels are fully independent, apart from the shared sync input and the shared config port.
- No combinational path exists from any input to tick.

Test Plan:
- Reset with CLK_FREQ=100, DEFAULT_FREQ=10 -> div_reg=10; ch0 en=1 periodic -> tick[0] high one cycle after edge 9, then at edges 19 and 29; tick=0 and active=0 while rst_n=0, including rst_n asserted mid-count (cnt=5) -> all outputs 0 immediately (async).
- Write cfg_ch=1, cfg_div=3, periodic -> ticks every 3 cycles. Write cfg_div=0 -> tick[1] constantly high. Write cfg_ch=5 with NUM_CH=4 -> no channel changes, phases undisturbed.
- ch2 one-shot, div=4, start at edge 0 -> tick[2] single pulse after edge 4, active high edges 0-3 then low. Start again at edge 2 of a new shot -> pulse moves to edge 6. Start while oneshot=0 -> no effect.
- ch0 div=4, ch1 div=6 free-running, sync pulse -> both cnt=0; next ticks 4 and 6 cycles later respectively, so they coincide again at 12.
- Write at the same edge ch3 hits TC (div=5 -> new 2) -> no tick that cycle, next tick 2 cycles later. sync coincident with TC -> no tick.
- Drop en mid-count (cnt=7 of div=10), re-raise -> count restarts at 0, first tick 10 cycles after re-enable. One-shot armed, en dropped -> armed cleared, no tick.
